// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared encodings for the Y86-64 pipeline control slice:
//   - instruction codes (I_HALT .. I_POPQ)
//   - status codes (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS)
//   - RNONE, the "no register" ID
//   - the control FSM state enum
//   - sat_inc, a saturating 32-bit increment used by the optional perf counters
// -----------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // {zf, sf, of} after reset: the "result was zero" state.
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ctrl_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cc_reg.sv
// -----------------------------------------------------------------------------
// cc_reg
// Architectural condition-code register {zf, sf, of} with write enable.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset, loads CC_RESET (zf=1, sf=0, of=0)
//   en    in   load d at the next rising edge
//   d     in   3  new {zf, sf, of}
//   q     out  3  registered {zf, sf, of}
// -----------------------------------------------------------------------------
module cc_reg
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);

  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= CC_RESET;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline control for the 5-stage Y86-64 core: detects load/use, branch
// mispredict, ret in flight and exception status, and drives the stall/bubble
// controls of the F/D/E/M/W registers. Owns the condition-code register.
// Optional build macro PIPE_PERF_CNT_EN adds saturating event counters.
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   D_icode, d_srcA, d_srcB    decode icode and source register IDs
//   E_icode, E_dstM, e_Cnd     execute icode, load destination, condition
//   e_zf, e_sf, e_of           execute flags (loaded when set_cc)
//   M_icode, m_stat, W_stat    memory icode/status, write-back status
//   F_stall, D_stall, W_stall  hold the register this cycle
//   D_bubble,E_bubble,M_bubble load a bubble this cycle
//   set_cc                     CC write enable this cycle
//   cc_zf, cc_sf, cc_of        registered condition codes
//   halted, halt_stat          frozen on non-AOK W_stat, and the status seen
//   cyc_cnt, lu_cnt, mp_cnt, ret_cnt  (PIPE_PERF_CNT_EN only) event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic        e_zf,
  input  logic        e_sf,
  input  logic        e_of,
  input  logic [3:0]  M_icode,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        W_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        set_cc,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic        halted,
  output logic [2:0]  halt_stat
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] lu_cnt,
  output logic [31:0] mp_cnt,
  output logic [31:0] ret_cnt
`endif
);

  ctrl_state_t state, state_nxt;
  logic        lu, mp, rt, ex;
  logic [2:0]  cc_q;

  // Hazard terms, evaluated on the current cycle's stage contents.
  assign lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mp = (E_icode == I_JXX) && !e_Cnd;
  assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign ex = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_INIT;
    else
      state <= state_nxt;
  end

  // Reset forces ST_INIT asynchronously, so the INIT outputs (F held, all
  // bubbles) are also what the pipeline sees while rst is high.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned.
    state_nxt = state;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    W_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    set_cc    = 1'b0;
    case (state)
      ST_INIT: begin
        F_stall   = 1'b1;
        D_bubble  = 1'b1;
        E_bubble  = 1'b1;
        M_bubble  = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = lu | rt;
        D_stall  = lu;
        // A load/use holds D, which takes priority over bubbling it for ret.
        D_bubble = mp | (rt & ~lu);
        E_bubble = mp | lu;
        M_bubble = ex;
        W_stall  = (W_stat != STAT_AOK);
        set_cc   = (E_icode == I_OPQ) && !ex;
        if (W_stat != STAT_AOK)
          state_nxt = ST_HALT;
      end
      ST_HALT: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign halted = (state == ST_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halt_stat <= STAT_AOK;
    else if ((state == ST_RUN) && (W_stat != STAT_AOK))
      halt_stat <= W_stat;
  end

  cc_reg u_cc_reg (
    .clk (clk),
    .rst (rst),
    .en  (set_cc),
    .d   ({e_zf, e_sf, e_of}),
    .q   (cc_q)
  );

  assign {cc_zf, cc_sf, cc_of} = cc_q;

`ifdef PIPE_PERF_CNT_EN
  // Counters advance only while running; INIT and HALT freeze them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
      ret_cnt <= '0;
    end else if (state == ST_RUN) begin
      cyc_cnt <= sat_inc(cyc_cnt);
      if (lu)       lu_cnt  <= sat_inc(lu_cnt);
      if (mp)       mp_cnt  <= sat_inc(mp_cnt);
      if (rt && !lu) ret_cnt <= sat_inc(ret_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic        e_Cnd, e_zf, e_sf, e_of;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
  logic        set_cc, cc_zf, cc_sf, cc_of, halted;
  logic [2:0]  halt_stat;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .e_zf(e_zf), .e_sf(e_sf), .e_of(e_of),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .halted(halted), .halt_stat(halt_stat)
`ifdef PIPE_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observed outputs: {F_stall, D_stall, W_stall, D_bub, E_bub, M_bub, set_cc, halted, cc[3], halt_stat[3]}
  logic [7:0]  obs_ctrl;
  logic [13:0] obs;
  assign obs_ctrl = {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted};
  assign obs      = {obs_ctrl, cc_zf, cc_sf, cc_of, halt_stat};

  // ---------------- reference model ----------------
  bit          m_init;   // first cycle after reset release
  bit          m_halt;   // pipeline frozen
  logic [2:0]  m_cc;
  logic [2:0]  m_hs;
  int unsigned m_cyc, m_lu, m_mp, m_ret;

  function automatic logic [3:0] hazards();  // {lu, mp, rt, ex}
    logic lu, mp, rt, ex;
    lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    mp = (E_icode == 4'h7) && !e_Cnd;
    rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    ex = (m_stat != 3'd1) || (W_stat != 3'd1);
    return {lu, mp, rt, ex};
  endfunction

  function automatic logic [7:0] model_ctrl();
    logic [3:0] h;
    logic f_s, d_s, w_s, d_b, e_b, m_b, scc;
    if (rst || m_init) return 8'b1001_1100;
    if (m_halt)        return 8'b1110_0001;
    h   = hazards();
    // Decode: a load/use holds it; otherwise a mispredict or ret squashes it.
    d_s = h[3];
    d_b = !h[3] && (h[2] || h[1]);
    f_s = h[3] || h[1];
    e_b = h[3] || h[2];
    m_b = h[0];
    w_s = (W_stat != 3'd1);
    scc = (E_icode == 4'h6) && !h[0];
    return {f_s, d_s, w_s, d_b, e_b, m_b, scc, 1'b0};
  endfunction

  function automatic logic [13:0] model_obs();
    return {model_ctrl(), m_cc, m_hs};
  endfunction

  task automatic model_reset();
    m_init = 1; m_halt = 0; m_cc = 3'b100; m_hs = 3'd1;
    m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    logic [7:0] c;
    logic [3:0] h;
    c = model_ctrl();
    h = hazards();
    @(posedge clk);
    if (!rst) begin
      if (m_init) m_init = 0;
      else if (!m_halt) begin
        m_cyc++;
        if (h[3]) m_lu++;
        if (h[2]) m_mp++;
        if (h[1] && !h[3]) m_ret++;
        if (c[1]) m_cc = {e_zf, e_sf, e_of};
        if (W_stat != 3'd1) begin m_halt = 1; m_hs = W_stat; end
      end
    end
    #1;
  endtask

  task automatic set_nop();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    e_Cnd = 1'b1; e_zf = 1'b0; e_sf = 1'b0; e_of = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  function automatic logic [3:0] rand_reg();
    int unsigned v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'hF : 4'(v);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; set_nop();
    #1 model_reset();
    @(negedge clk);
    checks++;
    if ({F_stall, D_bubble, E_bubble, M_bubble, halted} !== 5'b11110) begin
      $display("FAIL reset_ctrl: got %b want 11110", {F_stall, D_bubble, E_bubble, M_bubble, halted}); errors++;
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of, halt_stat} !== 6'b100_001) begin
      $display("FAIL reset_cc: got %b want 100001", {cc_zf, cc_sf, cc_of, halt_stat}); errors++;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_ctrl !== 8'b1001_1100) begin
      $display("FAIL init_cycle: got %b want 10011100", obs_ctrl); errors++;
    end
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 14'b0000_0000_100_001) begin
      $display("FAIL run_nop: got %b want 00000000100001", obs); errors++;
    end
    tick();
  endtask

  task automatic test_load_use();
    set_nop(); E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    @(negedge clk);
    checks++;
    if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110) begin
      $display("FAIL lu_hit: got %b want 1110", {F_stall, D_stall, E_bubble, D_bubble}); errors++;
    end
    tick();
    E_dstM = 4'hF;
    @(negedge clk);
    checks++;
    if (obs_ctrl !== 8'h00) begin
      $display("FAIL lu_rnone: got %b want 00000000", obs_ctrl); errors++;
    end
    tick();
    set_nop(); E_icode = 4'hB; E_dstM = 4'h2; d_srcA = 4'h2;
    @(negedge clk);
    checks++;
    if (obs !== model_obs()) begin
      $display("FAIL lu_popq: got %h want %h", obs, model_obs()); errors++;
    end
    tick();
  endtask

  task automatic test_mispredict();
    set_nop(); E_icode = 4'h7; e_Cnd = 1'b0;
    @(negedge clk);
    checks++;
    if ({D_bubble, E_bubble, F_stall} !== 3'b110) begin
      $display("FAIL mp_taken: got %b want 110", {D_bubble, E_bubble, F_stall}); errors++;
    end
    tick();
    e_Cnd = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_ctrl !== 8'h00) begin
      $display("FAIL mp_correct: got %b want 00000000", obs_ctrl); errors++;
    end
    tick();
    e_Cnd = 1'b0; D_icode = 4'h9;
    @(negedge clk);
    checks++;
    if ({F_stall, D_bubble, E_bubble, D_stall} !== 4'b1110) begin
      $display("FAIL mp_ret: got %b want 1110", {F_stall, D_bubble, E_bubble, D_stall}); errors++;
    end
    tick();
  endtask

  task automatic test_ret();
    for (int s = 0; s < 3; s++) begin
      set_nop();
      if (s == 0) D_icode = 4'h9;
      if (s == 1) E_icode = 4'h9;
      if (s == 2) M_icode = 4'h9;
      @(negedge clk);
      checks++;
      if ({F_stall, D_bubble, D_stall, E_bubble} !== 4'b1100) begin
        $display("FAIL ret_stage%0d: got %b want 1100", s, {F_stall, D_bubble, D_stall, E_bubble}); errors++;
      end
      tick();
    end
    set_nop(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    @(negedge clk);
    checks++;
    if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin
      $display("FAIL ret_lu: got %b want 1101", {F_stall, D_stall, D_bubble, E_bubble}); errors++;
    end
    tick();
  endtask

  task automatic test_cc();
    set_nop(); E_icode = 4'h6; e_zf = 1'b0; e_sf = 1'b1; e_of = 1'b0;
    @(negedge clk);
    checks++;
    if (set_cc !== 1'b1) begin
      $display("FAIL cc_set: got %b want 1", set_cc); errors++;
    end
    tick();
    set_nop();
    @(negedge clk);
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
      $display("FAIL cc_load: got %b want 010", {cc_zf, cc_sf, cc_of}); errors++;
    end
    E_icode = 4'h6; e_zf = 1'b1; e_sf = 1'b1; e_of = 1'b1; m_stat = 3'd3;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({set_cc, M_bubble} !== 2'b01) begin
      $display("FAIL cc_ex_ctrl: got %b want 01", {set_cc, M_bubble}); errors++;
    end
    tick();
    set_nop();
    @(negedge clk);
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
      $display("FAIL cc_ex_hold: got %b want 010", {cc_zf, cc_sf, cc_of}); errors++;
    end
    tick();
  endtask

  task automatic test_halt();
    set_nop(); W_stat = 3'd2;
    @(negedge clk);
    checks++;
    if ({W_stall, M_bubble, halted} !== 3'b110) begin
      $display("FAIL halt_entry: got %b want 110", {W_stall, M_bubble, halted}); errors++;
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      W_stat = 3'($urandom_range(1, 4)); E_icode = 4'h6;
      @(negedge clk);
      checks++;
      if ({halted, halt_stat, F_stall, D_stall, W_stall, set_cc} !== 8'b1_010_1110) begin
        $display("FAIL halt_hold%0d: got %b want 10101110", i, {halted, halt_stat, F_stall, D_stall, W_stall, set_cc}); errors++;
      end
      tick();
    end
    rst = 1'b1; model_reset();
    #1;
    checks++;
    if ({halted, F_stall, D_stall, D_bubble, halt_stat} !== 7'b0_101_001) begin
      $display("FAIL halt_rst: got %b want 0101001", {halted, F_stall, D_stall, D_bubble, halt_stat}); errors++;
    end
    set_nop();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== model_obs()) begin
      $display("FAIL halt_rst_init: got %h want %h", obs, model_obs()); errors++;
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 59) == 0) begin rst = 1'b1; model_reset(); end
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      d_srcA = rand_reg(); d_srcB = rand_reg(); E_dstM = rand_reg();
      e_Cnd = 1'($urandom); e_zf = 1'($urandom); e_sf = 1'($urandom); e_of = 1'($urandom);
      m_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      @(negedge clk);
      checks++;
      if (obs !== model_obs()) begin
        $display("FAIL rand_%0d: got %b want %b", n, obs, model_obs()); errors++;
      end
      tick();
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if ({cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== {m_cyc, m_lu, m_mp, m_ret}) begin
      $display("FAIL perf_cnt: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               cyc_cnt, lu_cnt, mp_cnt, ret_cnt, m_cyc, m_lu, m_mp, m_ret); errors++;
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_ret();
    test_cc();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
